// File: rtl/cordic_seq.sv
// Sequencer and result buffer for the iterative CORDIC sin/cos datapath.
// One angle in flight: latch, run ITERATIONS micro-rotations, capture, hand off.
module cordic_seq #(
  parameter int ITER_BITS  = 4,
  parameter int ITERATIONS = 15,
  parameter int Q1_14_BITS = 16,
  parameter int Q4_27_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Q4_27_BITS-1:0] in_angle,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Q1_14_BITS-1:0] out_cos,
  output logic [Q1_14_BITS-1:0] out_sin,
  output logic                  busy,
  output logic                  c_start,
  output logic [ITER_BITS-1:0]  c_iter,
  output logic [Q4_27_BITS-1:0] c_angle,
  output logic [Q4_27_BITS-1:0] c_atan,
  output logic [Q1_14_BITS-1:0] c_x0,
  output logic [Q1_14_BITS-1:0] c_y0,
  input  logic [Q1_14_BITS-1:0] c_cos,
  input  logic [Q1_14_BITS-1:0] c_sin
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, CAPT, OUT} state_t;

  state_t                state;
  logic [Q4_27_BITS-1:0] angle_q;
  logic [ITER_BITS-1:0]  iter_cnt;

  // round(atan(2^-k) * 2^27), indexed by iter = k+1; iter 0 means "not rotating"
  function automatic logic [31:0] atan_lut(input logic [ITER_BITS-1:0] i);
    logic [31:0] v;
    v = 32'h0;
    case (int'(i))
      1:  v = 32'h06487ED5;
      2:  v = 32'h03B58CE1;
      3:  v = 32'h01F5B760;
      4:  v = 32'h00FEADD5;
      5:  v = 32'h007FD56F;
      6:  v = 32'h003FFAAB;
      7:  v = 32'h001FFF55;
      8:  v = 32'h000FFFEB;
      9:  v = 32'h0007FFFD;
      10: v = 32'h00040000;
      11: v = 32'h00020000;
      12: v = 32'h00010000;
      13: v = 32'h00008000;
      14: v = 32'h00004000;
      15: v = 32'h00002000;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // iter_cnt is cleared on leaving ITER, so it doubles as the c_iter output
  assign c_iter  = iter_cnt;
  assign c_atan  = Q4_27_BITS'(atan_lut(iter_cnt));
  assign c_angle = angle_q;
  assign c_x0    = Q1_14_BITS'(16'h26DD);
  assign c_y0    = '0;

  // Handshake/control outputs are registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      angle_q   <= '0;
      iter_cnt  <= '0;
      out_cos   <= '0;
      out_sin   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      c_start   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          angle_q  <= in_angle;
          state    <= LOAD;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        LOAD: begin
          iter_cnt <= ITER_BITS'(1);
          c_start  <= 1'b1;
          state    <= ITER;
        end
        ITER: if (iter_cnt == ITER_BITS'(ITERATIONS)) begin
          iter_cnt <= '0;
          c_start  <= 1'b0;
          state    <= CAPT;
        end else begin
          iter_cnt <= iter_cnt + 1'b1;
        end
        CAPT: begin
          out_cos   <= c_cos;
          out_sin   <= c_sin;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          c_start   <= 1'b0;
          iter_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_seq.sv
// Bench for cordic_seq: a behavioural CORDIC datapath closes the loop, results are
// scoreboarded against known sin/cos values, plus stall and reset corner cases.
module tb_cordic_seq;
  localparam int IB = 4, IT = 15, QW = 16, AW = 32;
  localparam longint PI = 64'sd421657428;  // pi in Q4.27

  logic          clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, busy, c_start;
  logic [AW-1:0] in_angle, c_angle, c_atan;
  logic [QW-1:0] out_cos, out_sin, c_x0, c_y0, c_cos, c_sin;
  logic [IB-1:0] c_iter;

  always #5 clk = ~clk;

  cordic_seq #(.ITER_BITS(IB), .ITERATIONS(IT), .Q1_14_BITS(QW), .Q4_27_BITS(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
    .busy(busy), .c_start(c_start), .c_iter(c_iter), .c_angle(c_angle), .c_atan(c_atan),
    .c_x0(c_x0), .c_y0(c_y0), .c_cos(c_cos), .c_sin(c_sin));

  // Datapath model: x/y carry 8 extra fraction bits so its own rounding stays negligible
  function automatic longint wrap(input logic [AW-1:0] a);
    longint z = longint'($signed(a));
    while (z > PI) z -= 2 * PI;
    while (z <= -PI) z += 2 * PI;
    return z;
  endfunction
  function automatic bit flip_of(input logic [AW-1:0] a);
    longint z = wrap(a);
    return (z > PI / 2) || (z < -PI / 2);
  endfunction
  function automatic longint zmap(input logic [AW-1:0] a);
    longint z = wrap(a);
    if (z > PI / 2) return z - PI;
    if (z < -PI / 2) return z + PI;
    return z;
  endfunction
  function automatic longint rnd(input longint v);
    return (v + 128) >>> 8;
  endfunction

  longint mx = 0, my = 0, mz = 0;
  always @(posedge clk) begin
    if (!c_start) begin
      mx <= longint'($signed(c_x0)) <<< 8;
      my <= longint'($signed(c_y0)) <<< 8;
      mz <= zmap(c_angle);
    end else if (mz >= 0) begin
      mx <= mx - (my >>> (c_iter - 4'd1));
      my <= my + (mx >>> (c_iter - 4'd1));
      mz <= mz - longint'($signed(c_atan));
    end else begin
      mx <= mx + (my >>> (c_iter - 4'd1));
      my <= my - (mx >>> (c_iter - 4'd1));
      mz <= mz + longint'($signed(c_atan));
    end
  end
  assign c_cos = QW'(flip_of(c_angle) ? -rnd(mx) : rnd(mx));
  assign c_sin = QW'(flip_of(c_angle) ? -rnd(my) : rnd(my));

  function automatic longint lut_ref(input int k);
    real p = 1.0;
    for (int j = 0; j < k; j++) p = p / 2.0;
    return longint'($rtoi($atan(p) * 134217728.0 + 0.5));
  endfunction

  int tests = 0, fails = 0;
  typedef struct { logic [AW-1:0] angle; int cos_e; int sin_e; } vec_t;
  typedef struct { int c; int s; } exp_t;
  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
  task automatic chk_near(input string nm, input longint act, input longint exp);
    tests++;
    if (act > exp + 8 || act < exp - 8) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d +/-8", nm, act, exp);
    end
  endtask

  // Longest c_start run seen
  int run = 0, max_run = 0;
  always @(negedge clk) begin
    if (c_start) begin
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
  end

  // Returns just after the accepting edge with the expectation queued
  task automatic send(input logic [AW-1:0] a, input int ec, input int es);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_angle = a;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 100) begin
        tests++; fails++;
        $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, want 1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{ec, es});
  endtask

  // The accepting edge counts as edge 1; out_valid must rise on edge lat_exp
  task automatic collect(input logic [AW-1:0] a, input int lat_exp);
    int edges = 1, k = 0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) break;
      if (edges > 60) begin
        tests++; fails++;
        $display("FAIL out_valid_timeout: got none in 60 edges, want edge %0d", lat_exp);
        if (sb.size() > 0) void'(sb.pop_front());
        return;
      end
      if (c_start) begin
        k++;
        chk("c_iter", c_iter, k);
        chk("c_atan", $signed(c_atan), lut_ref(k - 1));
      end
    end
    chk("latency", edges, lat_exp);
    chk("iter_cycles", k, IT);
    chk("c_angle", c_angle, a);
    chk("busy_out", busy, 1);
    chk("in_ready_out", in_ready, 0);
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: got unexpected result, want none");
      return;
    end
    e = sb.pop_front();
    chk_near("out_cos", $signed(out_cos), e.c);
    chk_near("out_sin", $signed(out_sin), e.s);
    if (out_ready) begin
      @(posedge clk); #1;
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    logic [QW-1:0] hc, hs;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_angle = '0; out_ready = 1'b1;
    vecs[0] = '{32'h00000000,  16384,      0};
    vecs[1] = '{32'h0C90FDAA,      0,  16384};
    vecs[2] = '{32'h1921FB54, -16384,      0};
    vecs[3] = '{32'hFBCF5638,  14189,  -8192};
    vecs[4] = '{32'h06487ED5,  11585,  11585};
    vecs[5] = '{32'h25B2F8FE,      0, -16384};
    vecs[6] = '{32'h388C757D,  11585,  11585};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c_start", c_start, 0);
    chk("rst_c_iter", c_iter, 0);
    chk("rst_c_atan", c_atan, 0);
    chk("rst_c_angle", c_angle, 0);
    chk("rst_out_cos", out_cos, 0);
    chk("rst_out_sin", out_sin, 0);
    chk("c_x0", c_x0, 16'h26DD);
    chk("c_y0", c_y0, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].angle, vecs[i].cos_e, vecs[i].sin_e);
      chk("busy_accepted", busy, 1);
      collect(vecs[i].angle, IT + 3);
    end

    // Consumer stall with a request waiting
    out_ready = 1'b0;
    send(32'h06487ED5, 11585, 11585);
    collect(32'h06487ED5, IT + 3);
    hc = out_cos; hs = out_sin;
    in_valid = 1'b1; in_angle = 32'h0C90FDAA;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_cos", out_cos, hc);
      chk("hold_sin", out_sin, hs);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("waiting_req_accepted", busy, 1);
    sb.push_back('{0, 16384});
    collect(32'h0C90FDAA, IT + 3);

    // Reset while rotating at iter 7
    send(32'hFBCF5638, 14189, -8192);
    n = 0;
    while (c_iter != 4'd7 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_iter7", c_iter, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c_start", c_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_c_iter", c_iter, 0);
    send(32'h00000000, 16384, 0);
    collect(32'h00000000, IT + 3);

    // Reset while a result is waiting: it is discarded
    out_ready = 1'b0;
    send(32'h1921FB54, -16384, 0);
    collect(32'h1921FB54, IT + 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("outrst_out_valid", out_valid, 0);
    chk("outrst_out_cos", out_cos, 0);
    chk("outrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("outrst_no_result", out_valid, 0);

    chk("c_start_max_run", max_run, IT);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, want finish");
    $fatal(1, "watchdog");
  end
endmodule
